button_reader: RTL
==================

// Module: button_reader
// PURPOSE
//  Input-side counterpart to the LED blinker: reads one raw, bouncing push-button pin and turns it into
//  clean, debounced, single-cycle events in the PLL clock domain (clk0, 25 MHz on the board).
//  Sits between the board pad and user logic; provides a press level, press/release pulses, a press
//  counter and (optionally) a long-press pulse.
// PARAMETERS
//  DEBOUNCE_CYCLES    250000    cycles the synchronized input must stay stable to accept a change (>=2)
//  LONG_PRESS_CYCLES  25000000  cycles in HELD before long_pulse fires (>=2); used only with the macro
//  ACTIVE_LOW         1         1: pad reads 0 when pressed; 0: pad reads 1 when pressed
//  CNT_W              8         width of press_count
// PORTS
//  clk            in   1      clock (PLL CLK0 output)
//  rst_n          in   1      asynchronous active-low reset
//  btn            in   1      raw button pad, asynchronous to clk
//  pressed        out  1      debounced level, 1 while button is held
//  press_pulse    out  1      one-cycle pulse on accepted press
//  release_pulse  out  1      one-cycle pulse on accepted release
//  long_pulse     out  1      one-cycle pulse when a hold exceeds LONG_PRESS_CYCLES
//  press_count    out  CNT_W  number of accepted presses, wraps
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, all counters 0, all outputs 0.
//    Synchronizer FFs reset to the "released" pad level.
//  - btn passes a 2-FF synchronizer; s = synchronized value normalised so 1 = pressed (ACTIVE_LOW applied).
//  - FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE; one shared debounce counter cnt.
//    IDLE:        s=1 -> DEB_PRESS, cnt<=0.
//    DEB_PRESS:   s=0 -> IDLE (bounce, no event); s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; else cnt++.
//    HELD:        s=0 -> DEB_RELEASE, cnt<=0.
//    DEB_RELEASE: s=1 -> HELD (bounce, no event); s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt++.
//  - All outputs are registered.
//    Entering HELD from DEB_PRESS: press_pulse=1 for one cycle, pressed<=1, press_count++.
//    Entering IDLE from DEB_RELEASE: release_pulse=1 for one cycle, pressed<=0.
//  - Latency: raw edge stable before edge 1 -> press_pulse high after edge DEBOUNCE_CYCLES+3.
//    The release path uses the same latency.
//  - press_count is modulo 2^CNT_W (e.g. 255 -> 0); it never saturates.
//  - press_pulse and release_pulse are never high together. Bounce back to HELD/IDLE emits nothing.
//  - Reset mid-debounce or mid-hold aborts silently. If the button is still held after reset, a fresh
//    press is debounced and reported.
// CONFIGURATION
//  BUTTON_READER_LONG_PRESS_EN defined:
//   - A hold counter counts cycles in HELD and is cleared on entering HELD.
//   - At count == LONG_PRESS_CYCLES-1, long_pulse is high for one cycle; the counter then saturates,
//     so there is one long_pulse per hold.
//   - Bounce excursions into DEB_RELEASE do not clear the hold counter.
//  Macro undefined: long_pulse tied 0, hold counter not instantiated.
// STRUCTURE
//  - Shared package button_reader_pkg:
//     - 2-bit state encodings ST_IDLE=0, ST_DEB_PRESS=1, ST_HELD=2, ST_DEB_RELEASE=3
//     - clog2-based width helper for cnt and the hold counter
//  - Sub-module sync_2ff: 2-flop synchronizer with async active-low reset and a reset-value parameter.
//  - The FSM and counters are inline in button_reader.
// TESTING  (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, ACTIVE_LOW=1, CNT_W=8)
//  1. btn 1->0 held steady -> press_pulse high exactly after edge 7, pressed=1, press_count=1.
//  2. btn 0->1 held -> release_pulse one cycle after edge 7 of release, pressed=0, count unchanged.
//  3. btn low 2 cycles then high (glitch < debounce) -> no pulses, pressed stays 0, count stays 0.
//  4. btn pressed with a 2-cycle high glitch during hold -> no release_pulse, pressed stays 1.
//  5. 256 clean presses -> press_count wraps to 0.
//     Reset asserted mid-DEB_PRESS -> all outputs 0 immediately.
//  6. With BUTTON_READER_LONG_PRESS_EN: hold 40 cycles -> exactly one long_pulse, 16 cycles after
//     press_pulse. Without the macro, long_pulse stays 0.

Source files
------------

// File: rtl/button_reader_pkg.sv
// button_reader_pkg: shared state encodings and counter-width helper for button_reader.
package button_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    // Bits needed to hold the values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_reader_sync.sv
// sync_2ff: two-flop synchronizer with async active-low reset to a chosen level.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {r_meta, o_q} <= {RST_VAL, RST_VAL};
        else        {r_meta, o_q} <= {i_d, r_meta};
    end
endmodule

// File: rtl/button_reader.sv
// button_reader: debounces a raw push-button into a level, press/release pulses and a press counter.
// Optional long-press pulse enabled by defining BUTTON_READER_LONG_PRESS_EN.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter int ACTIVE_LOW        = 1,
    parameter int CNT_W             = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    output logic             pressed,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);
    localparam bit RST_LVL = (ACTIVE_LOW != 0);
    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          w_sync, w_s, w_press, w_release;
    logic [DW-1:0] r_cnt, w_cnt;
    state_t        r_state, w_next;

    // Synchronizer idles at the released pad level so reset never looks like a press.
    sync_2ff #(.RST_VAL(RST_LVL)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(btn), .o_q(w_sync));
    assign w_s = w_sync ^ RST_LVL;

    always_comb begin
        w_next    = r_state;
        w_cnt     = r_cnt;
        w_press   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ST_IDLE: if (w_s) begin
                w_next = ST_DEB_PRESS;
                w_cnt  = '0;
            end
            ST_DEB_PRESS: if (!w_s) w_next = ST_IDLE;
                else if (r_cnt == DMAX) begin
                    w_next  = ST_HELD;
                    w_press = 1'b1;
                end else w_cnt = r_cnt + 1'b1;
            ST_HELD: if (!w_s) begin
                w_next = ST_DEB_RELEASE;
                w_cnt  = '0;
            end
            ST_DEB_RELEASE: if (w_s) w_next = ST_HELD;
                else if (r_cnt == DMAX) begin
                    w_next    = ST_IDLE;
                    w_release = 1'b1;
                end else w_cnt = r_cnt + 1'b1;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt;
            press_pulse   <= w_press;
            release_pulse <= w_release;
            pressed       <= w_press ? 1'b1 : w_release ? 1'b0 : pressed;
            press_count   <= press_count + CNT_W'(w_press);
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam int HW = cnt_w(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HLAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HSAT  = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] r_hold;

    // Hold counter parks at HSAT after firing so each hold yields one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            long_pulse <= 1'b0;
        end else begin
            if (w_press) r_hold <= '0;
            else if (r_state == ST_HELD && r_hold != HSAT) r_hold <= r_hold + 1'b1;
            long_pulse <= (r_state == ST_HELD) && (r_hold == HLAST);
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule
